// File: rtl/vec_issue_ctrl.sv
// ----------------------------------------------------------------------------
// vec_issue_ctrl
//   Issue/scoreboard controller for the vector CPU. Dispatches decoded vector
//   instructions to NUM_ALU ALU units, one MEM unit and one LUT unit, blocks
//   RAW/WAW hazards with a pending-write bitmap, funnels unit completions onto
//   the single vector-register write port, and drains then halts on STP.
//
//   Unit order: ALU0..ALU(NUM_ALU-1), MEM, LUT.
//
// Ports:
//   clk, rst            clock, asynchronous active-high reset
//   dec_valid           decoded instruction present
//   dec_opcode          opcode (ALU 0x00-0x0D, MEM 0x0E-0x11, LUT 0x12, STP 0x1F)
//   dec_vd/vs1/vs2      destination / source vector register indices
//   pc_en               instruction accepted this cycle (advance fetch)
//   unit_st, unit_op    registered one-hot start pulse and opcode[3:0]
//   unit_done           per-unit result ready (level, held until acked)
//   unit_ack            one-hot completion acknowledge
//   vec_wr_en/idx       vector register file write strobe and index
//   unit_busy           per-unit occupancy
//   halted              STP retired and all units drained
//
// Optional: define VEC_ISSUE_PERF_EN to add perf_issue_cnt / perf_stall_cnt
// (saturating 32-bit accepted-instruction and stall-cycle counters).
// ----------------------------------------------------------------------------
module vec_issue_ctrl #(
    parameter  int OPC_W     = 5,
    parameter  int IDX_W     = 4,
    parameter  int NUM_ALU   = 2,
    localparam int NUM_UNITS = NUM_ALU + 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 dec_valid,
    input  logic [OPC_W-1:0]     dec_opcode,
    input  logic [IDX_W-1:0]     dec_vd,
    input  logic [IDX_W-1:0]     dec_vs1,
    input  logic [IDX_W-1:0]     dec_vs2,
    output logic                 pc_en,
    output logic [NUM_UNITS-1:0] unit_st,
    output logic [3:0]           unit_op,
    input  logic [NUM_UNITS-1:0] unit_done,
    output logic [NUM_UNITS-1:0] unit_ack,
    output logic                 vec_wr_en,
    output logic [IDX_W-1:0]     vec_wr_idx,
    output logic [NUM_UNITS-1:0] unit_busy,
    output logic                 halted
`ifdef VEC_ISSUE_PERF_EN
    ,
    output logic [31:0]          perf_issue_cnt,
    output logic [31:0]          perf_stall_cnt
`endif
);

    localparam int NREG   = 1 << IDX_W;
    localparam int UIDX_W = $clog2(NUM_UNITS);
    localparam logic [UIDX_W-1:0] MEM_U = UIDX_W'(NUM_ALU);
    localparam logic [UIDX_W-1:0] LUT_U = UIDX_W'(NUM_ALU + 1);

    typedef enum logic [1:0] {S_RUN, S_DRAIN, S_HALTED} state_e;

    state_e                 state_q, state_d;
    logic [NUM_UNITS-1:0]   busy_q, busy_d;
    logic [NUM_UNITS-1:0]   writes_q, writes_d;
    logic [IDX_W-1:0]       dest_q [NUM_UNITS];
    logic [IDX_W-1:0]       dest_d [NUM_UNITS];
    logic [NREG-1:0]        pending_q, pending_d;
    logic [NUM_UNITS-1:0]   unit_st_q, unit_st_d;
    logic [3:0]             unit_op_q, unit_op_d;

    // Opcode classification
    logic op_alu, op_mem, op_lut, op_stp, op_wr, op_vec;
    // Retirement arbitration
    logic [NUM_UNITS-1:0]   ret_vec;
    logic                   ret_valid;
    logic [UIDX_W-1:0]      ret_u;
    // Issue selection
    logic                   alu_free, tgt_free, hazard, issue;
    logic [UIDX_W-1:0]      alu_u, tgt_u;
    logic [NUM_UNITS-1:0]   issue_oh;

    always_comb begin
        op_alu = (dec_opcode <= OPC_W'(13));
        op_mem = (dec_opcode >= OPC_W'(14)) && (dec_opcode <= OPC_W'(17));
        op_lut = (dec_opcode == OPC_W'(18));
        op_stp = (dec_opcode == OPC_W'(31));
        op_vec = op_alu | op_mem | op_lut;
        // Only CV (0x0E) among the MEM ops produces a register result.
        op_wr  = op_alu | op_lut | (dec_opcode == OPC_W'(14));
    end

    // Lowest-index busy unit with done raised wins the write port; done on an
    // idle unit is masked off so it can never produce an ack.
    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned and no latch is inferred.
        ret_vec   = unit_done & busy_q;
        ret_valid = 1'b0;
        ret_u     = '0;
        for (int i = NUM_UNITS - 1; i >= 0; i--) begin
            if (ret_vec[i]) begin
                ret_valid = 1'b1;
                ret_u     = UIDX_W'(i);
            end
        end
    end

    assign unit_ack   = ret_valid ? (NUM_UNITS'(1) << ret_u) : '0;
    assign vec_wr_en  = ret_valid & writes_q[ret_u];
    assign vec_wr_idx = ret_valid ? dest_q[ret_u] : '0;

    // Issue checks use registered state only: a unit retiring this cycle is
    // still busy and a pending bit being cleared this cycle still blocks.
    always_comb begin
        alu_free = 1'b0;
        alu_u    = '0;
        for (int i = NUM_ALU - 1; i >= 0; i--) begin
            if (!busy_q[i]) begin
                alu_free = 1'b1;
                alu_u    = UIDX_W'(i);
            end
        end
        tgt_u    = op_alu ? alu_u : (op_mem ? MEM_U : LUT_U);
        tgt_free = op_alu ? alu_free : !busy_q[tgt_u];
        // Conservative: all three indices are checked for every vector op.
        hazard   = pending_q[dec_vs1] | pending_q[dec_vs2] | pending_q[dec_vd];
    end

    // FSM output logic
    always_comb begin
        pc_en  = 1'b0;
        halted = (state_q == S_HALTED);
        if (state_q == S_RUN && dec_valid)
            pc_en = op_vec ? (tgt_free && !hazard) : 1'b1;
    end

    assign issue    = pc_en & op_vec;
    assign issue_oh = issue ? (NUM_UNITS'(1) << tgt_u) : '0;

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_RUN:    if (pc_en && op_stp) state_d = S_DRAIN;
            S_DRAIN:  if (busy_q == '0)    state_d = S_HALTED;
            default:  state_d = S_HALTED;
        endcase
    end

    // Scoreboard next state
    always_comb begin
        busy_d    = (busy_q & ~unit_ack) | issue_oh;
        writes_d  = writes_q;
        dest_d    = dest_q;
        pending_d = pending_q;
        if (vec_wr_en)
            pending_d[vec_wr_idx] = 1'b0;
        if (issue) begin
            dest_d[tgt_u]   = dec_vd;
            writes_d[tgt_u] = op_wr;
            if (op_wr)
                pending_d[dec_vd] = 1'b1;
        end
        unit_st_d = issue_oh;
        unit_op_d = issue ? dec_opcode[3:0] : 4'h0;
    end

    // FSM state register and scoreboard registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: the pending bitmap and per-unit records are storage arrays
            // but are reset explicitly: a stale pending bit after reset would
            // block issue forever.
            state_q   <= S_RUN;
            busy_q    <= '0;
            writes_q  <= '0;
            pending_q <= '0;
            unit_st_q <= '0;
            unit_op_q <= '0;
            for (int i = 0; i < NUM_UNITS; i++)
                dest_q[i] <= '0;
        end else begin
            // NOTE: non-blocking assignments so every register samples the
            // pre-edge values regardless of statement order.
            state_q   <= state_d;
            busy_q    <= busy_d;
            writes_q  <= writes_d;
            pending_q <= pending_d;
            unit_st_q <= unit_st_d;
            unit_op_q <= unit_op_d;
            dest_q    <= dest_d;
        end
    end

    assign unit_st   = unit_st_q;
    assign unit_op   = unit_op_q;
    assign unit_busy = busy_q;

`ifdef VEC_ISSUE_PERF_EN
    logic [31:0] perf_issue_q, perf_stall_q;

    // pc_en is only ever high in RUN, so both counters freeze once halted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_issue_q <= '0;
            perf_stall_q <= '0;
        end else begin
            if (pc_en && perf_issue_q != '1)
                perf_issue_q <= perf_issue_q + 32'd1;
            if (state_q == S_RUN && dec_valid && !pc_en && perf_stall_q != '1)
                perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_issue_cnt = perf_issue_q;
    assign perf_stall_cnt = perf_stall_q;
`endif

endmodule

// File: tb/tb_vec_issue_ctrl.sv
// ----------------------------------------------------------------------------
// tb_vec_issue_ctrl
//   Directed bench for vec_issue_ctrl (NUM_ALU=2: ALU0=bit0, ALU1=bit1,
//   MEM=bit2, LUT=bit3). Expected retirements are queued when an instruction
//   is accepted and matched against unit_ack / vec_wr_en / vec_wr_idx when
//   the unit completes.
// ----------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_vec_issue_ctrl;

    localparam int NU = 4;
    localparam logic [4:0] OP_ADD = 5'h00;
    localparam logic [4:0] OP_CV  = 5'h0E;
    localparam logic [4:0] OP_GV  = 5'h0F;
    localparam logic [4:0] OP_LUT = 5'h12;
    localparam logic [4:0] OP_SCL = 5'h15;
    localparam logic [4:0] OP_STP = 5'h1F;

    logic          clk, rst;
    logic          dec_valid;
    logic [4:0]    dec_opcode;
    logic [3:0]    dec_vd, dec_vs1, dec_vs2;
    logic          pc_en;
    logic [NU-1:0] unit_st, unit_done, unit_ack, unit_busy;
    logic [3:0]    unit_op;
    logic          vec_wr_en;
    logic [3:0]    vec_wr_idx;
    logic          halted;

    typedef struct {
        int         unit;
        logic       wr;
        logic [3:0] idx;
    } exp_t;

    exp_t sb_q[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    vec_issue_ctrl #(.OPC_W(5), .IDX_W(4), .NUM_ALU(2)) dut (
        .clk        (clk),
        .rst        (rst),
        .dec_valid  (dec_valid),
        .dec_opcode (dec_opcode),
        .dec_vd     (dec_vd),
        .dec_vs1    (dec_vs1),
        .dec_vs2    (dec_vs2),
        .pc_en      (pc_en),
        .unit_st    (unit_st),
        .unit_op    (unit_op),
        .unit_done  (unit_done),
        .unit_ack   (unit_ack),
        .vec_wr_en  (vec_wr_en),
        .vec_wr_idx (vec_wr_idx),
        .unit_busy  (unit_busy),
        .halted     (halted)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] opc, input logic [3:0] vd,
                         input logic [3:0] vs1, input logic [3:0] vs2);
        dec_valid  = v;
        dec_opcode = opc;
        dec_vd     = vd;
        dec_vs1    = vs1;
        dec_vs2    = vs2;
    endtask

    task automatic push(input int unit, input logic wr, input logic [3:0] idx);
        exp_t e;
        e.unit = unit;
        e.wr   = wr;
        e.idx  = idx;
        sb_q.push_back(e);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_pc_en"},  pc_en,      0);
        check({tag, "_st"},     unit_st,    0);
        check({tag, "_op"},     unit_op,    0);
        check({tag, "_ack"},    unit_ack,   0);
        check({tag, "_wr_en"},  vec_wr_en,  0);
        check({tag, "_wr_idx"}, vec_wr_idx, 0);
        check({tag, "_busy"},   unit_busy,  0);
        check({tag, "_halted"}, halted,     0);
    endtask

    // Scoreboard: every ack is matched against the entry queued for that unit.
    always @(negedge clk) begin
        int u;
        int hit;
        if (!rst && unit_ack != '0) begin
            u   = -1;
            hit = -1;
            for (int i = NU - 1; i >= 0; i--)
                if (unit_ack[i]) u = i;
            check("sb_ack_onehot", 32'($onehot(unit_ack)), 1);
            foreach (sb_q[k])
                if (hit < 0 && sb_q[k].unit == u) hit = k;
            n_tests++;
            assert (hit >= 0) else begin
                n_fail++;
                $error("FAIL sb_unexpected_ack: observed ack on unit %0d expected no ack", u);
            end
            if (hit >= 0) begin
                check("sb_wr_en", vec_wr_en, sb_q[hit].wr);
                if (sb_q[hit].wr)
                    check("sb_wr_idx", vec_wr_idx, sb_q[hit].idx);
                sb_q.delete(hit);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL watchdog: observed timeout expected $finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst       = 1'b1;
        unit_done = '0;
        drive(0, 5'h0, 0, 0, 0);
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("rst");
        rst = 1'b0;
        tick();

        // Back-to-back independent ADDs: ALU0 then ALU1.
        drive(1, OP_ADD, 1, 0, 0); #1;
        check("add1_pc_en", pc_en, 1); push(0, 1, 1);
        tick();
        check("add1_st", unit_st, 4'b0001);
        check("add1_busy", unit_busy, 4'b0001);
        drive(1, OP_ADD, 2, 0, 0); #1;
        check("add2_pc_en", pc_en, 1); push(1, 1, 2);
        tick();
        check("add2_st", unit_st, 4'b0010);
        check("add2_busy", unit_busy, 4'b0011);

        // LUT op, then an ADD blocked by both ALUs busy.
        drive(1, OP_LUT, 4, 0, 0); #1;
        check("lut_pc_en", pc_en, 1); push(3, 1, 4);
        tick();
        check("lut_st", unit_st, 4'b1000);
        check("lut_op", unit_op, 4'h2);
        check("lut_busy", unit_busy, 4'b1011);
        drive(1, OP_ADD, 5, 0, 0); #1;
        check("alu_full_pc_en", pc_en, 0);
        tick();
        check("alu_full_st", unit_st, 4'b0000);

        // Contested completion: ALU0 and LUT together, ALU0 first.
        drive(0, 5'h0, 0, 0, 0);
        unit_done = 4'b1001; #1;
        check("cont1_ack", unit_ack, 4'b0001);
        check("cont1_wr_en", vec_wr_en, 1);
        check("cont1_wr_idx", vec_wr_idx, 1);
        tick();
        unit_done = 4'b1000; #1;
        check("cont2_busy", unit_busy, 4'b1010);
        check("cont2_ack", unit_ack, 4'b1000);
        check("cont2_wr_en", vec_wr_en, 1);
        check("cont2_wr_idx", vec_wr_idx, 4);
        tick();
        unit_done = '0; #1;
        check("cont3_ack", unit_ack, 4'b0000);
        check("cont3_busy", unit_busy, 4'b0010);

        // RAW: CV vd=3 then ADD vs1=3 stalls until MEM retires.
        drive(1, OP_CV, 3, 0, 0); #1;
        check("cv_pc_en", pc_en, 1); push(2, 1, 3);
        tick();
        check("cv_st", unit_st, 4'b0100);
        check("cv_busy", unit_busy, 4'b0110);
        drive(1, OP_ADD, 7, 3, 0); #1;
        check("raw_stall1", pc_en, 0);
        tick();
        check("raw_stall2", pc_en, 0);
        tick();
        unit_done = 4'b0100; #1;
        check("raw_ack", unit_ack, 4'b0100);
        check("raw_wr_en", vec_wr_en, 1);
        check("raw_wr_idx", vec_wr_idx, 3);
        check("raw_no_bypass", pc_en, 0);
        tick();
        unit_done = '0; #1;
        check("raw_accept", pc_en, 1); push(0, 1, 7);
        tick();
        drive(0, 5'h0, 0, 0, 0);
        check("raw_st", unit_st, 4'b0001);
        check("raw_busy", unit_busy, 4'b0011);
        unit_done = 4'b0001; #1;
        check("add7_ack", unit_ack, 4'b0001);
        tick();
        unit_done = '0;

        // Store (GV) writes nothing; an op on vd=0/vs1=5 issues in its ack cycle.
        drive(1, OP_GV, 0, 5, 0); #1;
        check("gv_pc_en", pc_en, 1); push(2, 0, 0);
        tick();
        check("gv_st", unit_st, 4'b0100);
        drive(1, OP_ADD, 0, 5, 0);
        unit_done = 4'b0100; #1;
        check("gv_ack", unit_ack, 4'b0100);
        check("gv_wr_en", vec_wr_en, 0);
        check("gv_no_pending", pc_en, 1); push(0, 1, 0);
        tick();
        unit_done = '0;
        drive(0, 5'h0, 0, 0, 0); #1;
        check("gv_add_st", unit_st, 4'b0001);
        check("gv_add_busy", unit_busy, 4'b0011);
        unit_done = 4'b0001; #1;
        check("add0_wr_idx", vec_wr_idx, 0);
        tick();
        unit_done = '0;

        // Scalar op on a pending register: accepted, no unit started.
        drive(1, OP_SCL, 2, 2, 2); #1;
        check("scl_pc_en", pc_en, 1);
        tick();
        drive(0, 5'h0, 0, 0, 0);
        check("scl_st", unit_st, 4'b0000);
        check("scl_busy", unit_busy, 4'b0010);

        // STP while ALU1 busy: drain, then halt.
        drive(1, OP_STP, 0, 0, 0); #1;
        check("stp_pc_en", pc_en, 1);
        tick();
        drive(1, OP_ADD, 9, 0, 0); #1;
        check("drain_pc_en", pc_en, 0);
        check("drain_halted", halted, 0);
        tick();
        check("drain_st", unit_st, 4'b0000);
        unit_done = 4'b0010; #1;
        check("drain_ack", unit_ack, 4'b0010);
        check("drain_wr_idx", vec_wr_idx, 2);
        check("drain_halted2", halted, 0);
        tick();
        unit_done = '0; #1;
        check("drain_busy", unit_busy, 4'b0000);
        check("drain_halted3", halted, 0);
        tick();
        check("halted", halted, 1);
        check("halted_pc_en", pc_en, 0);
        tick();
        check("halted_st", unit_st, 4'b0000);
        check("halted_hold", halted, 1);

        // Reset with three units busy.
        drive(0, 5'h0, 0, 0, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        tick();
        check("post_halt_rst", halted, 0);
        drive(1, OP_ADD, 1, 0, 0); #1;
        check("r_add1_pc_en", pc_en, 1); push(0, 1, 1);
        tick();
        drive(1, OP_ADD, 2, 0, 0); #1;
        check("r_add2_pc_en", pc_en, 1); push(1, 1, 2);
        tick();
        drive(1, OP_CV, 3, 0, 0); #1;
        check("r_cv_pc_en", pc_en, 1); push(2, 1, 3);
        tick();
        drive(0, 5'h0, 0, 0, 0); #1;
        check("r_busy3", unit_busy, 4'b0111);
        rst       = 1'b1;
        unit_done = 4'b0111; #1;
        check_all_zero("midrst");
        sb_q.delete();
        tick();
        tick();
        rst = 1'b0;
        drive(1, OP_ADD, 1, 3, 2); #1;
        check("post_rst_ack", unit_ack, 4'b0000);
        check("post_rst_wr_en", vec_wr_en, 0);
        check("post_rst_pc_en", pc_en, 1); push(0, 1, 1);
        unit_done = '0;
        tick();
        drive(0, 5'h0, 0, 0, 0);
        check("post_rst_st", unit_st, 4'b0001);
        check("post_rst_busy", unit_busy, 4'b0001);
        unit_done = 4'b0001; #1;
        check("post_rst_ret", unit_ack, 4'b0001);
        tick();
        unit_done = '0; #1;
        check("final_busy", unit_busy, 4'b0000);
        check("sb_empty", sb_q.size(), 0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/vec_issue_ctrl.md
Name: vec_issue_ctrl

Overview:
- Sequential issue/scoreboard controller for the vector CPU. Successor to the combinational stall decoder.
- Dispatches decoded vector instructions to NUM_ALU parallel ALU units, one MEM unit and one LUT unit.
- Tracks pending vector-register writes to block RAW/WAW hazards, serialises completions onto the single vector-register write port, and drains then halts on STP.

Parameters:
- OPC_W, 5, opcode width.
- IDX_W, 4, vector register index width (2**IDX_W registers).
- NUM_ALU, 2, number of ALU units, range 1..4.
- Derived localparam NUM_UNITS = NUM_ALU+2. Unit order: ALU0..ALU(NUM_ALU-1), then MEM, then LUT.

Ports:
- clk  in  1  clock.
- rst  in  1  asynchronous active-high reset.
- dec_valid  in  1  decoded instruction present.
- dec_opcode  in  OPC_W  opcode; same encoding as the current CPU.
- dec_vd  in  IDX_W  destination vector register.
- dec_vs1  in  IDX_W  source vector register 1.
- dec_vs2  in  IDX_W  source vector register 2.
- pc_en  out  1  advance fetch/decode; high in the same cycle an instruction is accepted.
- unit_st  out  NUM_UNITS  one-cycle start pulse, one-hot.
- unit_op  out  4  dec_opcode[3:0], registered alongside unit_st.
- unit_done  in  NUM_UNITS  unit result ready; level, held until acked.
- unit_ack  out  NUM_UNITS  one-hot completion acknowledge.
- vec_wr_en  out  1  vector register file write strobe.
- vec_wr_idx  out  IDX_W  write index.
- unit_busy  out  NUM_UNITS  unit occupied.
- halted  out  1  STP retired.

Behaviour:
- Reset:
  - All outputs 0.
  - Pending-write bitmap (2**IDX_W bits) cleared.
  - Per-unit dest/writes registers cleared.
  - FSM = RUN.
  - Asserting rst mid-operation abandons all in-flight ops; no write or ack follows.
- Opcode classes:
  - ALU: 0x00–0x0D; writes vd.
  - MEM: 0x0E–0x11; only 0x0E (CV) writes vd.
  - LUT: 0x12; writes vd.
  - STP: 0x1F.
  - All others are scalar: accepted immediately with no unit and no scoreboard effect.
- Issue conditions (all must hold, FSM=RUN, combinational on current state):
  - dec_valid=1.
  - Target unit idle. For ALU, the lowest-index idle ALU is chosen.
  - pending[vs1]=0, pending[vs2]=0, and pending[vd]=0. All three indices are checked for every vector op (conservative; no per-op usage decode).
- Issue actions:
  - pc_en=1 combinationally in the acceptance cycle.
  - Next edge: unit_st[u]=1 and unit_busy[u]=1.
  - dest[u]=vd and writes[u] are recorded.
  - pending[vd] is set if the op writes.
- When issue is blocked: pc_en=0, and no state changes except retirement.
- Retirement:
  - Among units with unit_done & unit_busy, the lowest index wins.
  - unit_ack[u] pulses for 1 cycle.
  - Same cycle: vec_wr_en=writes[u], vec_wr_idx=dest[u].
  - Next edge: pending[dest[u]] cleared and unit_busy[u]=0.
  - At most one retirement per cycle; losers keep done high and retire in later cycles.
- Simultaneous events:
  - Retire-clear and issue-set on the same register in one cycle: issue sees the pre-clear pending bit and stalls 1 cycle. No bypass.
  - Issue to a unit that is retiring the same cycle is not allowed; that unit is still busy.
  - unit_done on an idle unit is ignored; no ack is issued.
- FSM:
  - RUN: on accepted STP (pc_en=1) go to DRAIN.
  - DRAIN: no issue, pc_en=0; retirement continues. When unit_busy==0, go to HALTED.
  - HALTED: halted=1, pc_en=0. Leaves only on rst.
  - STP is accepted even when units are busy.
- Latency:
  - Issue to unit_st: 1 cycle.
  - unit_done to vec_wr_en: 0 cycles when uncontested.

Optional Feature:
- Macro: VEC_ISSUE_PERF_EN.
- When defined:
  - Adds outputs perf_issue_cnt[31:0] and perf_stall_cnt[31:0].
  - perf_issue_cnt increments on each accepted instruction.
  - perf_stall_cnt increments each RUN cycle with dec_valid=1 and pc_en=0.
  - Both saturate at 0xFFFFFFFF, reset to 0, and freeze in HALTED.
- When undefined: ports and counters are absent; all other behaviour is identical.

Test Plan:
- ALU ops with no hazard, NUM_ALU=2: ADD vd=1 and ADD vd=2 on back-to-back cycles.
  -> unit_st=0b0001 then 0b0010; both accepted with pc_en=1 on consecutive cycles.
- RAW hazard: CV vd=3, then ADD vs1=3.
  -> pc_en=0 until MEM done. Ack cycle: vec_wr_en=1, vec_wr_idx=3. ADD is accepted the following cycle.
- Contested completion: ALU0 and LUT raise done in the same cycle.
  -> ALU0 is acked first, LUT on the next cycle; two vec_wr_en pulses with the correct indices.
- Store with no write: GV vs1=5 completes.
  -> unit_ack[MEM]=1, vec_wr_en=0, and pending stays 0.
- STP while ALU1 is busy.
  -> FSM enters DRAIN and pc_en stays 0. halted=1 one cycle after ALU1 retires; a later dec_valid is ignored.
- rst pulsed while 3 units are busy.
  -> All outputs are 0 immediately. A later unit_done produces no ack. A new ADD issues in the first cycle after rst deasserts.
